// File: rtl/seq_detect_7seg_if.sv
// Bundles the serial-detector data and status signals between the
// stimulus side (master) and the detector (slave).
interface seq_detect_7seg_if;
  logic       x;
  logic       clr;
  logic       tick;
  logic       match;
  logic       y;
  logic [3:0] count;
  logic [6:0] seg;

  modport master (
    output x,
    output clr,
    input  tick,
    input  match,
    input  y,
    input  count,
    input  seg
  );

  modport slave (
    input  x,
    input  clr,
    output tick,
    output match,
    output y,
    output count,
    output seg
  );
endinterface

// File: rtl/seq_detect_7seg.sv
// Serial bit-pattern detector with sample-rate divider, wrapping match
// counter and active-low hex 7-segment display of the count.
module seq_detect_7seg #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = '0,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 DIV     = 20000000,
  parameter int                 DIV_W   = 27
) (
  input logic               clk,
  input logic               rst,
  seq_detect_7seg_if.slave  bus
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [DIV_W-1:0]   r_div_cnt;
  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_tick;
  logic               r_match;
  logic               r_y;
  logic [3:0]         r_count;
  logic [6:0]         r_seg;

  logic               w_sample;
  logic [DIV_W-1:0]   w_div_n;
  logic [PAT_LEN-1:0] w_shift;
  logic [FILL_W-1:0]  w_fill_inc;
  logic               w_hit;
  logic [PAT_LEN-1:0] w_hist_n;
  logic [FILL_W-1:0]  w_fill_n;
  logic [3:0]         w_count_n;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0000100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b0110001;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      4'hF:    return 7'b0111000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Next-state logic for divider, history, fill level and match counter
  always_comb begin
    w_sample   = (r_div_cnt == DIV_W'(DIV - 1));
    w_div_n    = r_div_cnt + DIV_W'(1);
    w_shift    = {r_hist[PAT_LEN-2:0], bus.x};
    w_fill_inc = r_fill;
    w_hit      = 1'b0;
    w_hist_n   = r_hist;
    w_fill_n   = r_fill;
    w_count_n  = r_count;

    if (w_sample) begin
      w_div_n = '0;
    end else begin
      w_div_n = r_div_cnt + DIV_W'(1);
    end

    // fill saturates at PAT_LEN; a hit needs a full window of real samples
    if (r_fill == FILL_W'(PAT_LEN)) begin
      w_fill_inc = r_fill;
    end else begin
      w_fill_inc = r_fill + FILL_W'(1);
    end

    w_hit = w_sample && (w_fill_inc == FILL_W'(PAT_LEN)) && (w_shift == PATTERN);

    if (w_sample) begin
      w_hist_n = w_shift;
      if (w_hit && (OVERLAP == 1'b0)) begin
        w_fill_n = '0;
      end else begin
        w_fill_n = w_fill_inc;
      end
    end else begin
      w_hist_n = r_hist;
      w_fill_n = r_fill;
    end

    if (bus.clr) begin
      w_count_n = 4'd0;
    end else if (w_hit) begin
      w_count_n = r_count + 4'd1;
    end else begin
      w_count_n = r_count;
    end
  end

  // State and output registers; seg is decoded from next count so it tracks count exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_tick    <= 1'b0;
      r_match   <= 1'b0;
      r_y       <= 1'b1;
      r_count   <= 4'd0;
      r_seg     <= 7'b0000001;
    end else begin
      r_div_cnt <= w_div_n;
      r_hist    <= w_hist_n;
      r_fill    <= w_fill_n;
      r_tick    <= w_sample;
      r_match   <= w_hit;
      r_y       <= w_sample ? ~w_hit : r_y;
      r_count   <= w_count_n;
      r_seg     <= seg_decode(w_count_n);
    end
  end

  assign bus.tick  = r_tick;
  assign bus.match = r_match;
  assign bus.y     = r_y;
  assign bus.count = r_count;
  assign bus.seg   = r_seg;

endmodule
